// File: rtl/dispatch_sink_ctr.sv
// Byte-stream dispatcher: routes fixed-length bursts to one of two sinks,
// each with its own output FIFO; sink 2 receives bit-reversed bytes.
module dispatch_sink_ctr #(
  parameter int unsigned BURST_LEN = 512,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag,
  input  logic       en_in,
  input  logic [7:0] din,
  input  logic       rdy1,
  output logic       en1,
  output logic [7:0] dout1,
  input  logic       rdy2,
  output logic       en2,
  output logic [7:0] dout2,
  output logic       busy,
  output logic       ovf
);

  localparam int unsigned CW = 16;
  localparam int unsigned OW = AW + 1;

  typedef enum logic {IDLE, ROUTE} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_sel, w_sel_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_dst;

  logic [7:0]      r_mem1 [DEPTH];
  logic [7:0]      r_mem2 [DEPTH];
  logic [AW-1:0]   r_wp1, r_rp1, r_wp2, r_rp2;
  logic [OW-1:0]   r_occ1, r_occ2, w_occ1_nxt, w_occ2_nxt;
  logic            w_wr1, w_wr2, w_full1, w_full2;
  logic            w_push1, w_push2, w_pop1, w_pop2, w_drop;
  logic [7:0]      w_din_rev;

  logic            r_en1, r_en2, r_busy, r_ovf;
  logic [7:0]      r_dout1, r_dout2;

  // Burst framing state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sel   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: flag is only honoured on the first byte of a burst
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_dst       = r_sel;
    case (r_state)
      IDLE: begin
        w_dst = flag;
        if (en_in) begin
          w_sel_nxt = flag;
          if (BURST_LEN == 1) begin
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt   = CW'(1);
            w_state_nxt = ROUTE;
          end
        end
      end
      ROUTE: begin
        if (en_in) begin
          if (r_cnt == CW'(BURST_LEN - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_din_rev = '0;
    for (int i = 0; i < 8; i++) w_din_rev[i] = din[7-i];
  end

  // Push when space exists or the head leaves in the same cycle; else drop
  assign w_wr1      = en_in & ~w_dst;
  assign w_wr2      = en_in & w_dst;
  assign w_full1    = (r_occ1 == OW'(DEPTH));
  assign w_full2    = (r_occ2 == OW'(DEPTH));
  assign w_pop1     = (r_occ1 != '0) & rdy1;
  assign w_pop2     = (r_occ2 != '0) & rdy2;
  assign w_push1    = w_wr1 & (~w_full1 | w_pop1);
  assign w_push2    = w_wr2 & (~w_full2 | w_pop2);
  assign w_drop     = (w_wr1 & ~w_push1) | (w_wr2 & ~w_push2);
  assign w_occ1_nxt = r_occ1 + OW'(w_push1) - OW'(w_pop1);
  assign w_occ2_nxt = r_occ2 + OW'(w_push2) - OW'(w_pop2);

  always_ff @(posedge clk) begin
    if (w_push1) r_mem1[r_wp1] <= din;
    if (w_push2) r_mem2[r_wp2] <= w_din_rev;
  end

  // FIFO pointers, occupancy, sink output registers and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp1   <= '0;
      r_rp1   <= '0;
      r_wp2   <= '0;
      r_rp2   <= '0;
      r_occ1  <= '0;
      r_occ2  <= '0;
      r_en1   <= 1'b0;
      r_en2   <= 1'b0;
      r_dout1 <= '0;
      r_dout2 <= '0;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push1) r_wp1 <= r_wp1 + AW'(1);
      if (w_push2) r_wp2 <= r_wp2 + AW'(1);
      if (w_pop1) begin
        r_rp1   <= r_rp1 + AW'(1);
        r_dout1 <= r_mem1[r_rp1];
      end
      if (w_pop2) begin
        r_rp2   <= r_rp2 + AW'(1);
        r_dout2 <= r_mem2[r_rp2];
      end
      r_occ1 <= w_occ1_nxt;
      r_occ2 <= w_occ2_nxt;
      r_en1  <= w_pop1;
      r_en2  <= w_pop2;
      r_busy <= (w_state_nxt == ROUTE) | (w_occ1_nxt != '0) | (w_occ2_nxt != '0);
      r_ovf  <= r_ovf | w_drop;
    end
  end

  assign en1   = r_en1;
  assign en2   = r_en2;
  assign dout1 = r_dout1;
  assign dout2 = r_dout2;
  assign busy  = r_busy;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_dispatch_sink_ctr.sv
// Scoreboard bench for dispatch_sink_ctr with BURST_LEN=4, DEPTH=4.
module tb_dispatch_sink_ctr;

  logic       clk, rst_n, flag, en_in, rdy1, rdy2;
  logic [7:0] din;
  logic       en1, en2, busy, ovf;
  logic [7:0] dout1, dout2;

  int vectors    = 0;
  int miscompares = 0;
  int n_en1 = 0;
  int n_en2 = 0;
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  dispatch_sink_ctr #(.BURST_LEN(4), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .flag(flag), .en_in(en_in), .din(din),
    .rdy1(rdy1), .en1(en1), .dout1(dout1),
    .rdy2(rdy2), .en2(en2), .dout2(dout2),
    .busy(busy), .ovf(ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Scoreboard: every sink strobe must match the oldest expected byte
  always @(negedge clk) begin
    if (rst_n) begin
      if (en1) begin
        logic [7:0] e;
        n_en1++;
        vectors++;
        if (q1.size() == 0) begin
          miscompares++;
          $display("FAIL sink1_unexpected: got %02h, none expected", dout1);
        end else begin
          e = q1.pop_front();
          if (dout1 !== e) begin
            miscompares++;
            $display("FAIL sink1_data: got %02h, expected %02h", dout1, e);
          end
        end
      end
      if (en2) begin
        logic [7:0] e;
        n_en2++;
        vectors++;
        if (q2.size() == 0) begin
          miscompares++;
          $display("FAIL sink2_unexpected: got %02h, none expected", dout2);
        end else begin
          e = q2.pop_front();
          if (dout2 !== e) begin
            miscompares++;
            $display("FAIL sink2_data: got %02h, expected %02h", dout2, e);
          end
        end
      end
    end
  end

  task automatic send(input logic f, input logic [7:0] d);
    flag  = f;
    din   = d;
    en_in = 1'b1;
    @(posedge clk);
    #1;
    en_in = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flag = 1'b0; en_in = 1'b0; din = '0; rdy1 = 1'b1; rdy2 = 1'b1;
    #3;
    vectors++;
    if ({en1, en2, busy, ovf} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got en1/en2/busy/ovf=%b, expected 0000", {en1, en2, busy, ovf});
    end
    vectors++;
    if ({dout1, dout2} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_data: got %04h, expected 0000", {dout1, dout2});
    end
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_sink1;
    int e1, e2;
    logic [7:0] bytes [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    e1 = n_en1; e2 = n_en2;
    rdy1 = 1'b1; rdy2 = 1'b1;
    for (int i = 0; i < 4; i++) q1.push_back(bytes[i]);
    send(1'b0, bytes[0]);
    vectors++;
    if (en1 !== 1'b0) begin
      miscompares++;
      $display("FAIL sink1_latency_early: en1=%b, expected 0", en1);
    end
    send(1'b0, bytes[1]);
    vectors++;
    if (en1 !== 1'b1 || dout1 !== 8'h01) begin
      miscompares++;
      $display("FAIL sink1_latency: en1=%b dout1=%02h, expected 1/01", en1, dout1);
    end
    send(1'b0, bytes[2]);
    send(1'b0, bytes[3]);
    for (int i = 0; i < 30 && (busy || q1.size() != 0); i++) idle_cycles(1);
    idle_cycles(1);
    vectors++;
    if (busy !== 1'b0 || q1.size() != 0 || (n_en1 - e1) != 4 || n_en2 != e2) begin
      miscompares++;
      $display("FAIL sink1_burst: busy=%b left=%0d en1s=%0d en2s=%0d, expected 0/0/4/0",
               busy, q1.size(), n_en1 - e1, n_en2 - e2);
    end
  endtask

  task automatic test_sink2_reverse;
    int e1;
    logic [7:0] bytes [4] = '{8'h01, 8'h80, 8'h0F, 8'hA5};
    e1 = n_en1;
    for (int i = 0; i < 4; i++) q2.push_back(rev8(bytes[i]));
    for (int i = 0; i < 4; i++) send(1'b1, bytes[i]);
    for (int i = 0; i < 30 && (busy || q2.size() != 0); i++) idle_cycles(1);
    idle_cycles(1);
    vectors++;
    if (q2.size() != 0 || n_en1 != e1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sink2_burst: left=%0d en1s=%0d busy=%b, expected 0/0/0", q2.size(), n_en1 - e1, busy);
    end
  endtask

  task automatic test_flag_ignored;
    int e1, e2;
    e1 = n_en1; e2 = n_en2;
    for (int i = 0; i < 4; i++) q1.push_back(8'hA0 + 8'(i));
    for (int i = 0; i < 4; i++) q2.push_back(rev8(8'hB0 + 8'(i)));
    send(1'b0, 8'hA0);
    send(1'b0, 8'hA1);
    send(1'b1, 8'hA2);
    send(1'b1, 8'hA3);
    for (int i = 0; i < 4; i++) send(1'b1, 8'hB0 + 8'(i));
    for (int i = 0; i < 30 && (busy || q1.size() != 0 || q2.size() != 0); i++) idle_cycles(1);
    idle_cycles(1);
    vectors++;
    if ((n_en1 - e1) != 4 || (n_en2 - e2) != 4 || q1.size() != 0 || q2.size() != 0) begin
      miscompares++;
      $display("FAIL flag_mid_burst: en1s=%0d en2s=%0d, expected 4/4", n_en1 - e1, n_en2 - e2);
    end
  endtask

  task automatic test_independent;
    int e1, e2;
    e1 = n_en1; e2 = n_en2;
    rdy2 = 1'b0; rdy1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q2.push_back(rev8(8'h30 + 8'(i)));
      send(1'b1, 8'h30 + 8'(i));
    end
    for (int i = 0; i < 4; i++) begin
      q1.push_back(8'h40 + 8'(i));
      send(1'b0, 8'h40 + 8'(i));
    end
    for (int i = 0; i < 30 && q1.size() != 0; i++) idle_cycles(1);
    idle_cycles(2);
    vectors++;
    if ((n_en1 - e1) != 4 || n_en2 != e2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL independent_hold: en1s=%0d en2s=%0d busy=%b, expected 4/0/1", n_en1 - e1, n_en2 - e2, busy);
    end
    rdy2 = 1'b1;
    for (int i = 0; i < 30 && (busy || q2.size() != 0); i++) idle_cycles(1);
    idle_cycles(1);
    vectors++;
    if ((n_en2 - e2) != 4 || q2.size() != 0 || ovf !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL independent_drain: en2s=%0d ovf=%b busy=%b, expected 4/0/0", n_en2 - e2, ovf, busy);
    end
  endtask

  task automatic test_overflow;
    int e1, e2;
    e1 = n_en1; e2 = n_en2;
    rdy1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) q1.push_back(8'h50 + 8'(i));
      send(1'b0, 8'h50 + 8'(i));
    end
    vectors++;
    if (ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set: ovf=%b, expected 1", ovf);
    end
    send(1'b0, 8'h56);
    send(1'b0, 8'h57);
    // framing must be back at burst start: next burst goes to sink 2
    for (int i = 0; i < 4; i++) begin
      q2.push_back(rev8(8'h60 + 8'(i)));
      send(1'b1, 8'h60 + 8'(i));
    end
    idle_cycles(6);
    vectors++;
    if ((n_en2 - e2) != 4 || n_en1 != e1 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_framing: en2s=%0d en1s=%0d ovf=%b, expected 4/0/1", n_en2 - e2, n_en1 - e1, ovf);
    end
    rdy1 = 1'b1;
    for (int i = 0; i < 30 && (busy || q1.size() != 0); i++) idle_cycles(1);
    idle_cycles(3);
    vectors++;
    if ((n_en1 - e1) != 4 || q1.size() != 0 || ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_drain: en1s=%0d left=%0d ovf=%b, expected 4/0/1", n_en1 - e1, q1.size(), ovf);
    end
  endtask

  task automatic test_reset_mid_burst;
    int e1, e2;
    rdy1 = 1'b0;
    send(1'b0, 8'h11);
    send(1'b0, 8'h22);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({en1, en2, busy, ovf, dout1, dout2} !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_async: en1/en2/busy/ovf=%b dout1=%02h dout2=%02h, expected all 0",
               {en1, en2, busy, ovf}, dout1, dout2);
    end
    @(posedge clk);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    e1 = n_en1; e2 = n_en2;
    rdy1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q2.push_back(rev8(8'hC0 + 8'(i)));
      send(1'b1, 8'hC0 + 8'(i));
    end
    for (int i = 0; i < 30 && (busy || q2.size() != 0); i++) idle_cycles(1);
    idle_cycles(2);
    vectors++;
    if ((n_en2 - e2) != 4 || n_en1 != e1 || ovf !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_restart: en2s=%0d en1s=%0d ovf=%b busy=%b, expected 4/0/0/0",
               n_en2 - e2, n_en1 - e1, ovf, busy);
    end
  endtask

  initial begin
    test_reset;
    test_sink1;
    test_sink2_reverse;
    test_flag_ignored;
    test_independent;
    test_overflow;
    test_reset_mid_burst;
    vectors++;
    if (q1.size() != 0 || q2.size() != 0) begin
      miscompares++;
      $display("FAIL leftover_expected: q1=%0d q2=%0d, expected 0/0", q1.size(), q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dispatch_sink_ctr.md
Name: dispatch_sink_ctr

Overview:
- Receive-side counterpart of the host/flash source selector.
- Takes one byte stream (en_in/din) and dispatches it in fixed-length bursts to one of two sinks: sink 1 gets bytes unchanged; sink 2 gets bytes bit-reversed (din[0] to dout2[7], and so on).
- Each sink has a small output FIFO with a ready input, so a stalled sink does not block the other path.
- Sits between the SSD data path and the two byte consumers.

Parameters:
- BURST_LEN, 512: bytes per burst (1..65535); the destination is fixed for the whole burst.
- DEPTH, 8: entries per sink FIFO (power of two, at least 2).
- AW, 3: log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flag  in  1  destination select (0 = sink 1, 1 = sink 2); sampled only on the first byte of a burst.
- en_in  in  1  input byte valid; one byte per cycle in which it is high.
- din  in  8  input byte.
- rdy1  in  1  sink 1 can accept a byte this cycle.
- en1  out  1  sink 1 byte strobe; one cycle per byte.
- dout1  out  8  sink 1 byte, unchanged.
- rdy2  in  1  sink 2 can accept a byte this cycle.
- en2  out  1  sink 2 byte strobe.
- dout2  out  8  sink 2 byte, bit-reversed.
- busy  out  1  high while a burst is open or either FIFO is non-empty.
- ovf  out  1  sticky overflow flag; cleared only by reset.

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n. Asserting rst_n low immediately drives the following, including mid-burst:
  - en1, en2, ovf, busy = 0; dout1, dout2 = 0.
  - FSM = IDLE; byte counter = 0; sel = 0.
  - Both FIFOs empty; any in-flight data is discarded.
- FSM states IDLE and ROUTE.
  - IDLE, en_in high: latch sel <= flag and route the byte to the selected FIFO. Counter <= 1. Go to ROUTE, unless BURST_LEN == 1, in which case stay in IDLE.
  - ROUTE, en_in high: route the byte to FIFO[sel] and increment the counter. When the counter reaches BURST_LEN, clear it and return to IDLE. The next byte then starts a new burst and re-samples flag.
  - ROUTE, en_in low: hold state and counter. There is no timeout.
  - flag changes during ROUTE are ignored.
- Bit reversal is applied when writing into FIFO 2. FIFO 2 therefore stores reversed bytes.
- FIFO push:
  - A routed byte is written if the FIFO is not full, or if it is full and popping in the same cycle.
  - Otherwise the byte is dropped and ovf is set to 1. The burst counter still advances, so burst framing is preserved.
- FIFO pop, per sink x:
  - If FIFO x is non-empty and rdy_x is high at an edge, the head entry is registered onto dout_x and en_x = 1 for the next cycle.
  - Otherwise en_x = 0 and dout_x holds its last value.
- Latency:
  - Byte accepted at edge N into an empty FIFO with rdy_x high: en_x high in the cycle after edge N+1 (2 clocks).
  - Sustained throughput is 1 byte/clock per sink while rdy_x stays high.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged. This is legal when full and when holding a single entry.
- Sink 1 and sink 2 drain independently and concurrently. Draining the previous burst's FIFO while the new burst fills the other FIFO is allowed.
- busy = (state == ROUTE) | FIFO1 non-empty | FIFO2 non-empty, registered.
- Counter width is 16 bits, with no wrap inside a burst.

Test Plan (BURST_LEN=4, DEPTH=4):
- flag=0, en_in high 4 cycles with din=01,02,03,04, rdy1=1 -> en1 high 4 consecutive cycles starting 2 clocks after the first byte; dout1=01,02,03,04; en2 never high; busy returns to 0 afterwards.
- flag=1, din=01,80,0F,A5 -> dout2=80,01,F0,A5 in order; en1 never high.
- flag=0 on the first byte, toggled to 1 after byte 2; then a second burst with flag=1 -> all 4 bytes of burst 1 on sink 1, all 4 bytes of burst 2 on sink 2.
- rdy1=0, 6 bytes to sink 1 (two bursts with flag=0) -> FIFO full after 4; bytes 5 and 6 dropped; ovf=1 and stays 1; releasing rdy1 gives exactly 4 bytes; state is IDLE after byte 8 framing.
- Burst to sink 2 with rdy2=0, then a burst to sink 1 with rdy1=1 -> sink 1 drains while sink 2 holds; raising rdy2 then drains sink 2; no loss; ovf=0.
- rst_n pulsed low after byte 2 of a burst -> all outputs 0 immediately; FIFOs empty; next en_in byte starts a new burst and samples flag.
